bch_syndrome_serial: RTL and testbench
======================================

Name: bch_syndrome_serial

Overview:
- Bit-serial syndrome generator for the BCH decoder.
- Consumes one received codeword bit per accepted beat, MSB first (the coefficient of x^(N-1) arrives first).
- Computes S_1..S_2T in GF(2^M), standard basis, by Horner evaluation at alpha^j.
- Presents the syndromes to the downstream key-equation/divider stage through a valid/ready hold register.

Parameters:
- M, 4, field degree; field polynomial is BCH_POLYNOMIAL(M).
- T, 2, correction capability; 2T syndromes are produced.
- N, 2^M-1, codeword length in bits; legal range 2T+1 .. 2^M-1.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new codeword; clears the accumulators.
- in_valid  input  1  data_in is valid this cycle.
- in_ready  output  1  block accepts a bit this cycle.
- data_in  input  1  received codeword bit.
- syn_valid  output  1  syndromes complete and held.
- syn_ready  input  1  downstream consumes the syndromes.
- syndromes  output  2*T*M  S_j at [(j-1)*M +: M], j = 1..2T.
- err_detected  output  1  OR of all syndrome bits; valid while syn_valid is high.

Behaviour:
- Reset: synchronous, active-high, clock clk, with priority over all other inputs.
  - State goes to IDLE.
  - All syndrome registers, the bit counter, syn_valid, in_ready and err_detected go to 0.
  - Reset mid-codeword or mid-hold discards all data.
- States:
  - IDLE: in_ready=0, syn_valid=0.
  - ACCUM: in_ready=1.
  - HOLD: syn_valid=1, in_ready=0.
- Transitions:
  - IDLE + start -> ACCUM. Accumulators and counter are cleared in the same edge.
  - ACCUM + start -> ACCUM. This restarts the codeword: accumulators cleared, counter cleared. If in_valid is also high that cycle, the bit is dropped (start wins).
  - ACCUM + in_valid (beat accepted):
    - S_j <= S_j*alpha^j XOR {0..0,data_in} for all j in parallel.
    - The counter increments.
  - ACCUM, beat accepted with counter == N-1 -> HOLD on the same edge. syn_valid rises the cycle after the N-th bit.
  - HOLD + syn_ready -> IDLE. Syndromes stay registered and unchanged until the next start.
  - HOLD + start: ignored. Upstream must wait for the handoff.
  - IDLE + in_valid: ignored.
- Arithmetic:
  - Constant multiplication by alpha^j uses lpow(M, j) as the constant operand of a parallel standard-basis multiplier.
  - All arithmetic is GF(2); there is no carry.
  - The counter is log2(N+1) bits wide and never wraps within a codeword.
- Latency:
  - N accepted beats plus 1 cycle to syn_valid.
  - Throughput is one bit per cycle when in_valid is held high.
- Gaps: any number of in_valid=0 cycles inside ACCUM leave the state unchanged.
- err_detected is registered together with the final syndrome update.

Decomposition:
- Shared package bch.vh provides:
  - lpow, log2, BCH_POLYNOMIAL, BCH_MUL1.
  - State encodings as localparams IDLE/ACCUM/HOLD.
- One sub-module, bch_syndrome_lane (parameters M, J):
  - Holds a single M-bit accumulator.
  - Applies the constant multiply by alpha^J and the XOR with data_in.
  - Inputs: clk, clear, ce, bit. Output: S.
- The top level instantiates 2T lanes and owns the FSM, the counter and the handshake.

Test Plan:
- All 15 bits zero (M=4, poly x^4+x+1, T=2):
  - syn_valid rises exactly 1 cycle after the 15th beat.
  - All syndromes = 0000 and err_detected=0.
- Only the last bit (x^0) is 1:
  - S1=S2=S3=S4=0001.
  - err_detected=1.
- Only bit 14 of 15 (the x^1 coefficient) is 1:
  - S1=0010, S2=0100, S3=1000, S4=0011.
- Same stimulus as the x^1 case with random in_valid gaps and syn_ready held low for 10 cycles:
  - Identical syndromes.
  - syn_valid remains high and the values stay stable.
  - start pulses during HOLD are ignored.
  - The block goes to IDLE on the cycle after syn_ready=1.
- start asserted after 7 beats, then a full all-zero codeword:
  - Syndromes are all 0, with no residue from the first 7 beats.
- reset asserted mid-ACCUM and mid-HOLD:
  - The next cycle shows in_ready=0, syn_valid=0, syndromes=0.
  - A following full codeword produces correct results.

Source files
------------

// File: rtl/bch_syndrome_serial_pkg.sv
// Shared GF(2^M) helpers and FSM state encoding for the bit-serial BCH syndrome block.
// All helpers are constant functions evaluated at elaboration time.
package bch_syndrome_serial_pkg;

   localparam int MAX_M = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Primitive polynomial including the x^M term.
   function automatic logic [MAX_M:0] BCH_POLYNOMIAL(input int m);
      logic [MAX_M:0] p;
      case (m)
         2:       p = 17'h00007;
         3:       p = 17'h0000B;
         4:       p = 17'h00013;
         5:       p = 17'h00025;
         6:       p = 17'h00043;
         7:       p = 17'h00089;
         8:       p = 17'h0011D;
         9:       p = 17'h00211;
         10:      p = 17'h00409;
         11:      p = 17'h00805;
         12:      p = 17'h01053;
         13:      p = 17'h0201B;
         14:      p = 17'h04443;
         15:      p = 17'h08003;
         16:      p = 17'h1100B;
         default: p = 17'h00013;
      endcase
      return p;
   endfunction

   function automatic logic [MAX_M-1:0] BCH_MUL1(input int m, input logic [MAX_M-1:0] a);
      logic [MAX_M:0]   poly;
      logic [MAX_M-1:0] r;
      poly = BCH_POLYNOMIAL(m);
      r    = a << 1;
      if (a[m-1])
         r = r ^ poly[MAX_M-1:0];
      for (int i = m; i < MAX_M; i++)
         r[i] = 1'b0;
      return r;
   endfunction

   function automatic logic [MAX_M-1:0] lpow(input int m, input int j);
      logic [MAX_M-1:0] r;
      int               e;
      r = 16'h0001;
      e = j % ((1 << m) - 1);
      for (int k = 0; k < e; k++)
         r = BCH_MUL1(m, r);
      return r;
   endfunction

   // Ceiling log2.
   function automatic int log2(input int x);
      int r;
      r = 0;
      for (int k = 0; k < 32; k++)
         if ((1 << r) < x)
            r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/bch_syndrome_lane.sv
// One syndrome accumulator: S <= S*alpha^J ^ bit (Horner step), standard basis.
// s_next exposes the pending update so the top can register err together with it.
module bch_syndrome_lane
   import bch_syndrome_serial_pkg::*;
#(
   parameter int M = 4,
   parameter int J = 1
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         ce,
   input  logic         data_bit,
   output logic [M-1:0] s,
   output logic [M-1:0] s_next
);

   localparam logic [MAX_M:0]   POLY_FULL    = BCH_POLYNOMIAL(M);
   localparam logic [M-1:0]     POLY         = POLY_FULL[M-1:0];
   localparam logic [MAX_M-1:0] ALPHA_J_FULL = lpow(M, J);
   localparam logic [M-1:0]     ALPHA_J      = ALPHA_J_FULL[M-1:0];

   logic [M-1:0] r_s;
   logic [M-1:0] w_prod;
   logic [M-1:0] w_term;

   // Constant multiplier: sum of S[i] * (alpha^J * alpha^i).
   always_comb begin
      w_prod = '0;
      w_term = ALPHA_J;
      for (int i = 0; i < M; i++) begin
         if (r_s[i])
            w_prod = w_prod ^ w_term;
         w_term = {w_term[M-2:0], 1'b0} ^ (w_term[M-1] ? POLY : '0);
      end
   end

   assign s_next = w_prod ^ {{(M-1){1'b0}}, data_bit};

   always_ff @(posedge clk) begin
      if (clear)
         r_s <= '0;
      else if (ce)
         r_s <= s_next;
   end

   assign s = r_s;

endmodule

// File: rtl/bch_syndrome_serial.sv
// Bit-serial BCH syndrome generator: 2T Horner lanes, beat counter, and a
// valid/ready hold stage towards the key-equation solver.
module bch_syndrome_serial
   import bch_syndrome_serial_pkg::*;
#(
   parameter int M = 4,
   parameter int T = 2,
   parameter int N = (1 << M) - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             data_in,
   output logic             syn_valid,
   input  logic             syn_ready,
   output logic [2*T*M-1:0] syndromes,
   output logic             err_detected
);

   localparam int            CW   = log2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t          r_state;
   state_t          w_state_next;
   logic [CW-1:0]   r_cnt;
   logic            r_err;
   logic            w_clear;
   logic            w_lane_clear;
   logic            w_ce;
   logic            w_last;
   logic [2*T*M-1:0] w_syn_next;

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      syn_valid    = 1'b0;
      w_clear      = 1'b0;
      w_ce         = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_clear      = 1'b1;
               w_state_next = ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            // A restart takes priority over a simultaneous data beat.
            if (start)
               w_clear = 1'b1;
            else if (in_valid) begin
               w_ce = 1'b1;
               if (r_cnt == LAST) begin
                  w_last       = 1'b1;
                  w_state_next = HOLD;
               end
            end
         end
         HOLD: begin
            syn_valid = 1'b1;
            if (syn_ready)
               w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (reset || w_clear)
         r_cnt <= '0;
      else if (w_ce)
         r_cnt <= r_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset || w_clear)
         r_err <= 1'b0;
      else if (w_last)
         r_err <= |w_syn_next;
   end

   assign w_lane_clear = reset | w_clear;
   assign err_detected = r_err;

   generate
      for (genvar gi = 0; gi < 2*T; gi++) begin : g_lane
         bch_syndrome_lane #(
            .M (M),
            .J (gi + 1)
         ) u_lane (
            .clk      (clk),
            .clear    (w_lane_clear),
            .ce       (w_ce),
            .data_bit (data_in),
            .s        (syndromes[gi*M +: M]),
            .s_next   (w_syn_next[gi*M +: M])
         );
      end
   endgenerate

endmodule

// File: tb/tb_bch_syndrome_serial.sv
// Directed bench for bch_syndrome_serial at M=4 (x^4+x+1), T=2, N=15.
// Expected syndromes {S4,S3,S2,S1} are hand-computed powers of alpha.
module tb_bch_syndrome_serial;

   logic        clk;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic        data_in;
   logic        syn_valid;
   logic        syn_ready;
   logic [15:0] syndromes;
   logic        err_detected;

   int n_checks;
   int n_fail;

   bch_syndrome_serial #(
      .M (4),
      .T (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .data_in      (data_in),
      .syn_valid    (syn_valid),
      .syn_ready    (syn_ready),
      .syndromes    (syndromes),
      .err_detected (err_detected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [14:0] cw;
      logic [15:0] syn;
      logic        err;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end else
         $display("ok   %s: %0h", name, got);
   endtask

   // start pulse, then 15 beats MSB first, optional random gaps
   task automatic send_cw(input logic [14:0] cw, input bit gaps, input bit dirty_start);
      start    = 1'b1;
      in_valid = dirty_start;
      data_in  = dirty_start;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      for (int i = 14; i >= 0; i--) begin
         int g;
         g = gaps ? int'($urandom_range(0, 2)) : 0;
         repeat (g) begin
            in_valid = 1'b0;
            data_in  = 1'b1;
            tick();
         end
         in_valid = 1'b1;
         data_in  = cw[i];
         if (i == 14)
            check("in_ready_first_beat", 32'(in_ready), 32'd1);
         if (i == 0)
            check("syn_valid_before_last", 32'(syn_valid), 32'd0);
         tick();
      end
      in_valid = 1'b0;
      data_in  = 1'b0;
   endtask

   task automatic check_hold(input string tag, input logic [15:0] exp_syn, input logic exp_err);
      check({tag, "_syn_valid"}, 32'(syn_valid), 32'd1);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_syndromes"}, 32'(syndromes), 32'(exp_syn));
      check({tag, "_err"}, 32'(err_detected), 32'(exp_err));
   endtask

   task automatic handoff(input string tag, input logic [15:0] exp_syn);
      syn_ready = 1'b1;
      tick();
      syn_ready = 1'b0;
      check({tag, "_idle_syn_valid"}, 32'(syn_valid), 32'd0);
      check({tag, "_idle_syndromes"}, 32'(syndromes), 32'(exp_syn));
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_syn_valid"}, 32'(syn_valid), 32'd0);
      check({tag, "_syndromes"}, 32'(syndromes), 32'd0);
      check({tag, "_err"}, 32'(err_detected), 32'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      data_in   = 1'b0;
      syn_ready = 1'b0;

      vecs[0] = '{15'h0000, 16'h0000, 1'b0};  // all zero
      vecs[1] = '{15'h0001, 16'h1111, 1'b1};  // x^0
      vecs[2] = '{15'h0002, 16'h3842, 1'b1};  // x^1 -> alpha^j
      vecs[3] = '{15'h0004, 16'h5C34, 1'b1};  // x^2 -> alpha^2j
      vecs[4] = '{15'h4000, 16'hEFD9, 1'b1};  // x^14 -> alpha^-j
      vecs[5] = '{15'h7FFF, 16'h0000, 1'b0};  // all ones sums to zero
      vecs[6] = '{15'h0003, 16'h2953, 1'b1};  // x^1 + 1

      tick();
      tick();
      check_cleared("reset");
      reset = 1'b0;

      for (int v = 0; v < 7; v++) begin
         send_cw(vecs[v].cw, 1'b0, 1'b0);
         check_hold($sformatf("vec%0d", v), vecs[v].syn, vecs[v].err);
         handoff($sformatf("vec%0d", v), vecs[v].syn);
      end

      // in_valid while IDLE must not start anything
      in_valid = 1'b1;
      data_in  = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      check("idle_ignore_in_ready", 32'(in_ready), 32'd0);
      check("idle_ignore_syn_valid", 32'(syn_valid), 32'd0);

      // gapped x^1 codeword, stalled downstream with start pulses in HOLD
      send_cw(15'h0002, 1'b1, 1'b0);
      check_hold("gaps", 16'h3842, 1'b1);
      for (int k = 0; k < 10; k++) begin
         start = (k % 2 == 0);
         tick();
         check($sformatf("stall%0d_syn_valid", k), 32'(syn_valid), 32'd1);
         check($sformatf("stall%0d_syndromes", k), 32'(syndromes), 32'h3842);
      end
      start = 1'b0;
      handoff("gaps", 16'h3842);

      // restart after 7 nonzero beats; start also wins over a same-cycle beat
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) begin
         in_valid = 1'b1;
         data_in  = 1'b1;
         tick();
      end
      send_cw(15'h0000, 1'b0, 1'b1);
      check_hold("restart", 16'h0000, 1'b0);
      handoff("restart", 16'h0000);

      // reset mid-ACCUM
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) begin
         in_valid = 1'b1;
         data_in  = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      check_cleared("rst_accum");
      reset = 1'b0;
      send_cw(15'h4000, 1'b0, 1'b0);
      check_hold("after_rst_accum", 16'hEFD9, 1'b1);

      // reset mid-HOLD
      reset = 1'b1;
      tick();
      check_cleared("rst_hold");
      reset = 1'b0;
      send_cw(15'h0001, 1'b0, 1'b0);
      check_hold("after_rst_hold", 16'h1111, 1'b1);
      handoff("after_rst_hold", 16'h1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
